// File: rtl/cmac_link_supervisor.sv
// cmac_link_supervisor
// Link supervisor for a 100G CMAC RX/TX path in the rx_clk domain. It holds
// the RS-FEC and control ports static, runs the PCS alignment state machine
// with a timeout and a bounded retry count, pulses the transceiver RX reset,
// and gates axis_rx so that downstream only ever sees whole frames after each
// reset.
//
// Optional feature: define CMAC_LINK_STATS_EN to build the saturating
// link_up_count / link_down_count statistics. Without it both outputs are 0.
//
// rx_out handshake: there is no ready. A beat is transferred on every cycle
// rx_out_tvalid is high, and the consumer must accept it. rx_out_tvalid is
// rx_in_tvalid qualified by a registered pass flag. Every other rx_out field
// is a zero-latency copy of rx_in.
module cmac_link_supervisor #(
  parameter int FREQ_HZ          = 322265625,
  parameter int RSFEC            = 1,
  parameter int ALIGN_TIMEOUT_MS = 2000,
  parameter int RESET_CYCLES     = 50,
  parameter int SILENCE_US       = 1000,
  parameter int MAX_RETRIES      = 0,
  parameter int DATA_W           = 512
) (
  input  logic                  rx_clk,
  input  logic                  sys_reset_in,
  input  logic                  reset_req,
  input  logic                  stat_rx_aligned,

  output logic                  ctl_rx_rsfec_enable,
  output logic                  ctl_rx_rsfec_enable_correction,
  output logic                  ctl_rx_rsfec_enable_indication,
  output logic                  ctl_tx_rsfec_enable,
  output logic                  ctl_rx_enable,
  output logic                  ctl_tx_enable,
  output logic                  ctl_tx_send_rfi,

  output logic                  sys_reset_out,
  output logic                  link_up,
  output logic                  link_failed,
  output logic [7:0]            retry_count,
  output logic [15:0]           link_up_count,
  output logic [15:0]           link_down_count,
  output logic [1:0]            dbg_state,

  input  logic [DATA_W-1:0]     rx_in_tdata,
  input  logic [DATA_W/8-1:0]   rx_in_tkeep,
  input  logic                  rx_in_tlast,
  input  logic                  rx_in_tuser,
  input  logic                  rx_in_tvalid,

  output logic [DATA_W-1:0]     rx_out_tdata,
  output logic [DATA_W/8-1:0]   rx_out_tkeep,
  output logic                  rx_out_tlast,
  output logic                  rx_out_tuser,
  output logic                  rx_out_tvalid
);

  // Timer reload values, all computed at elaboration in 64-bit arithmetic.
  localparam logic [31:0] RESET_LOAD   = 32'(RESET_CYCLES);
  localparam logic [31:0] ALIGN_LOAD   = 32'(64'(FREQ_HZ) / 64'd1000 * 64'(ALIGN_TIMEOUT_MS));
  localparam logic [31:0] SILENCE_LOAD = 32'(64'(FREQ_HZ) / 64'd1000000 * 64'(SILENCE_US));
  localparam logic [31:0] MAX_RETRY_W  = 32'(MAX_RETRIES);
  localparam logic        RSFEC_ON     = (RSFEC != 0);

  typedef enum logic [1:0] {
    ST_RESET      = 2'd0,
    ST_WAIT_ALIGN = 2'd1,
    ST_UP         = 2'd2,
    ST_FAILED     = 2'd3
  } state_t;

  state_t      state;
  logic [31:0] reset_timer;
  logic [31:0] align_timer;
  logic [31:0] silence_timer;
  logic [2:0]  aligned_sync;
  logic        sync_aligned;
  logic        in_frame;
  logic        pass;

  logic [7:0]  retry_inc;
  logic        timeout;
  logic        fail_now;
  logic        up_enter;
  logic        up_exit;
  logic        go_reset;
  logic        go_failed;

  // Static control ports.
  assign ctl_rx_rsfec_enable            = RSFEC_ON;
  assign ctl_rx_rsfec_enable_correction = RSFEC_ON;
  assign ctl_rx_rsfec_enable_indication = RSFEC_ON;
  assign ctl_tx_rsfec_enable            = RSFEC_ON;
  assign ctl_rx_enable                  = 1'b1;
  assign ctl_tx_send_rfi                = ~ctl_tx_enable;
  assign dbg_state                      = state;
  assign sync_aligned                   = aligned_sync[2];

  // Three-stage synchronizer for the asynchronous PCS alignment status.
  always_ff @(posedge rx_clk or posedge sys_reset_in) begin
    if (sys_reset_in) begin
      aligned_sync <= 3'b000;
    end else begin
      aligned_sync <= {aligned_sync[1:0], stat_rx_aligned};
    end
  end

  // Transition decode; reset_req overrides every other transition.
  always_comb begin
    retry_inc = (retry_count == 8'hFF) ? 8'hFF : retry_count + 8'd1;
    timeout   = (state == ST_WAIT_ALIGN) && !sync_aligned && (align_timer == '0);
    fail_now  = timeout && (MAX_RETRY_W != '0) && (32'(retry_inc) == MAX_RETRY_W);
    up_enter  = !reset_req && (state == ST_WAIT_ALIGN) && sync_aligned;
    up_exit   = (state == ST_UP) && (reset_req || !sync_aligned);
    go_reset  = reset_req
              || ((state == ST_UP) && !sync_aligned)
              || (timeout && !fail_now);
    go_failed = !reset_req && fail_now;
  end

  // Link state machine with its timers, retry counter and registered outputs.
  always_ff @(posedge rx_clk or posedge sys_reset_in) begin
    if (sys_reset_in) begin
      state         <= ST_RESET;
      reset_timer   <= RESET_LOAD;
      align_timer   <= '0;
      silence_timer <= SILENCE_LOAD;
      retry_count   <= '0;
      sys_reset_out <= 1'b1;
      ctl_tx_enable <= 1'b0;
      link_up       <= 1'b0;
      link_failed   <= 1'b0;
    end else begin
      // Countdowns saturate at zero; any reload below overrides the decrement.
      if (reset_timer != '0) reset_timer <= reset_timer - 32'd1;
      if (align_timer != '0) align_timer <= align_timer - 32'd1;
      if (silence_timer != '0) silence_timer <= silence_timer - 32'd1;

      if (go_reset) begin
        state         <= ST_RESET;
        reset_timer   <= RESET_LOAD;
        silence_timer <= SILENCE_LOAD;
        sys_reset_out <= (RESET_LOAD != '0);
        ctl_tx_enable <= 1'b0;
        link_up       <= 1'b0;
        link_failed   <= 1'b0;
      end else if (go_failed) begin
        state         <= ST_FAILED;
        sys_reset_out <= 1'b0;
        ctl_tx_enable <= 1'b0;
        link_up       <= 1'b0;
        link_failed   <= 1'b1;
      end else if (up_enter) begin
        state         <= ST_UP;
        ctl_tx_enable <= 1'b1;
        link_up       <= 1'b1;
      end else if ((state == ST_RESET) && (reset_timer == '0)) begin
        state         <= ST_WAIT_ALIGN;
        align_timer   <= ALIGN_LOAD;
      end else if ((state == ST_RESET) && (reset_timer == 32'd1)) begin
        // Last cycle of the pulse: the timer reaches zero on this edge.
        sys_reset_out <= 1'b0;
      end

      if (reset_req || up_enter) begin
        retry_count <= '0;
      end else if (timeout) begin
        retry_count <= retry_inc;
      end
    end
  end

  // Frame tracking on rx_in and the pass flag that gates rx_out_tvalid.
  always_ff @(posedge rx_clk or posedge sys_reset_in) begin
    if (sys_reset_in) begin
      in_frame <= 1'b0;
      pass     <= 1'b0;
    end else begin
      if (rx_in_tvalid) begin
        in_frame <= !rx_in_tlast;
      end
      if (up_exit) begin
        pass <= 1'b0;
      end else if ((state == ST_UP) && (silence_timer == '0) && !in_frame) begin
        pass <= 1'b1;
      end
    end
  end

  assign rx_out_tdata  = rx_in_tdata;
  assign rx_out_tkeep  = rx_in_tkeep;
  assign rx_out_tlast  = rx_in_tlast;
  assign rx_out_tuser  = rx_in_tuser;
  assign rx_out_tvalid = rx_in_tvalid & pass;

`ifdef CMAC_LINK_STATS_EN
  logic [15:0] up_cnt;
  logic [15:0] down_cnt;

  // Saturating link statistics; only the hard reset clears them.
  always_ff @(posedge rx_clk or posedge sys_reset_in) begin
    if (sys_reset_in) begin
      up_cnt   <= '0;
      down_cnt <= '0;
    end else begin
      if (up_enter && (up_cnt != 16'hFFFF)) begin
        up_cnt <= up_cnt + 16'd1;
      end
      if (up_exit && (down_cnt != 16'hFFFF)) begin
        down_cnt <= down_cnt + 16'd1;
      end
    end
  end

  assign link_up_count   = up_cnt;
  assign link_down_count = down_cnt;
`else
  assign link_up_count   = 16'd0;
  assign link_down_count = 16'd0;
`endif

endmodule

// File: tb/tb_cmac_link_supervisor.sv
// Directed testbench for cmac_link_supervisor with a small timing setup:
// 1 MHz clock scaling, 2 ms alignment timeout (2000 cycles), 50-cycle reset
// pulse, 10 us silence (10 cycles), 3 retries before FAILED.
module tb_cmac_link_supervisor;

  localparam int DATA_W = 64;
  localparam logic [1:0] S_RESET = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_UP    = 2'd2;
  localparam logic [1:0] S_FAIL  = 2'd3;

  logic                rx_clk;
  logic                sys_reset_in;
  logic                reset_req;
  logic                stat_rx_aligned;
  logic                ctl_rx_rsfec_enable;
  logic                ctl_rx_rsfec_enable_correction;
  logic                ctl_rx_rsfec_enable_indication;
  logic                ctl_tx_rsfec_enable;
  logic                ctl_rx_enable;
  logic                ctl_tx_enable;
  logic                ctl_tx_send_rfi;
  logic                sys_reset_out;
  logic                link_up;
  logic                link_failed;
  logic [7:0]          retry_count;
  logic [15:0]         link_up_count;
  logic [15:0]         link_down_count;
  logic [1:0]          dbg_state;
  logic [DATA_W-1:0]   rx_in_tdata;
  logic [DATA_W/8-1:0] rx_in_tkeep;
  logic                rx_in_tlast;
  logic                rx_in_tuser;
  logic                rx_in_tvalid;
  logic [DATA_W-1:0]   rx_out_tdata;
  logic [DATA_W/8-1:0] rx_out_tkeep;
  logic                rx_out_tlast;
  logic                rx_out_tuser;
  logic                rx_out_tvalid;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  logic [DATA_W-1:0] exp_q[$];

  cmac_link_supervisor #(
    .FREQ_HZ(1000000), .RSFEC(1), .ALIGN_TIMEOUT_MS(2), .RESET_CYCLES(50),
    .SILENCE_US(10), .MAX_RETRIES(3), .DATA_W(DATA_W)
  ) dut (
    .rx_clk(rx_clk), .sys_reset_in(sys_reset_in), .reset_req(reset_req),
    .stat_rx_aligned(stat_rx_aligned),
    .ctl_rx_rsfec_enable(ctl_rx_rsfec_enable),
    .ctl_rx_rsfec_enable_correction(ctl_rx_rsfec_enable_correction),
    .ctl_rx_rsfec_enable_indication(ctl_rx_rsfec_enable_indication),
    .ctl_tx_rsfec_enable(ctl_tx_rsfec_enable), .ctl_rx_enable(ctl_rx_enable),
    .ctl_tx_enable(ctl_tx_enable), .ctl_tx_send_rfi(ctl_tx_send_rfi),
    .sys_reset_out(sys_reset_out), .link_up(link_up), .link_failed(link_failed),
    .retry_count(retry_count), .link_up_count(link_up_count),
    .link_down_count(link_down_count), .dbg_state(dbg_state),
    .rx_in_tdata(rx_in_tdata), .rx_in_tkeep(rx_in_tkeep), .rx_in_tlast(rx_in_tlast),
    .rx_in_tuser(rx_in_tuser), .rx_in_tvalid(rx_in_tvalid),
    .rx_out_tdata(rx_out_tdata), .rx_out_tkeep(rx_out_tkeep), .rx_out_tlast(rx_out_tlast),
    .rx_out_tuser(rx_out_tuser), .rx_out_tvalid(rx_out_tvalid)
  );

  // Clock and cycle counter.
  initial begin
    rx_clk = 1'b0;
    forever #5 rx_clk = ~rx_clk;
  end

  always @(posedge rx_clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one cycle and land just after the active edge.
  task automatic step();
    @(posedge rx_clk);
    #1;
  endtask

  task automatic wait_state(input string tag, input logic [1:0] st, input int budget);
    int n;
    n = 0;
    while (dbg_state != st && n < budget) begin
      step();
      n++;
    end
    check_eq(tag, 64'(dbg_state), 64'(st));
  endtask

  // Drive one rx_in beat, let the comb path settle, check the gate, and
  // score the data of every beat expected to come out.
  task automatic beat(input logic [DATA_W-1:0] d, input logic last, input logic valid,
                      input logic exp_valid, input string tag);
    rx_in_tdata  = d;
    rx_in_tlast  = last;
    rx_in_tvalid = valid;
    if (exp_valid) exp_q.push_back(d);
    #1;
    check_eq(tag, 64'(rx_out_tvalid), 64'(exp_valid));
    if (rx_out_tvalid && exp_q.size() > 0) begin
      check_eq({tag, " data"}, 64'(rx_out_tdata), 64'(exp_q.pop_front()));
    end
  endtask

  // Count samples with sys_reset_out high, starting at the current one.
  task automatic count_reset_pulse(input string tag);
    int n;
    n = 0;
    while (sys_reset_out && n < 200) begin
      n++;
      step();
    end
    check_eq(tag, 64'(n), 64'd50);
  endtask

  initial begin
    int w_cyc;
    int t_cyc;
    sys_reset_in    = 1'b1;
    reset_req       = 1'b0;
    stat_rx_aligned = 1'b0;
    rx_in_tdata     = 64'h1122_3344_5566_7788;
    rx_in_tkeep     = 8'hA5;
    rx_in_tlast     = 1'b1;
    rx_in_tuser     = 1'b1;
    rx_in_tvalid    = 1'b1;
    repeat (3) step();

    // Reset values, with a valid beat offered on rx_in.
    check_eq("rst sys_reset_out", 64'(sys_reset_out), 64'd1);
    check_eq("rst tx_enable", 64'(ctl_tx_enable), 64'd0);
    check_eq("rst send_rfi", 64'(ctl_tx_send_rfi), 64'd1);
    check_eq("rst link_up", 64'(link_up), 64'd0);
    check_eq("rst link_failed", 64'(link_failed), 64'd0);
    check_eq("rst rx_out_tvalid", 64'(rx_out_tvalid), 64'd0);
    check_eq("rst retry_count", 64'(retry_count), 64'd0);
    check_eq("rst state", 64'(dbg_state), 64'(S_RESET));
    check_eq("static ctl", 64'({ctl_rx_rsfec_enable, ctl_rx_rsfec_enable_correction,
                               ctl_rx_rsfec_enable_indication, ctl_tx_rsfec_enable,
                               ctl_rx_enable}), 64'h1F);
    check_eq("passthru tdata", 64'(rx_out_tdata), 64'h1122_3344_5566_7788);
    check_eq("passthru tkeep", 64'(rx_out_tkeep), 64'hA5);
    check_eq("passthru tuser/tlast", 64'({rx_out_tuser, rx_out_tlast}), 64'h3);
    rx_in_tvalid = 1'b0;

    // Release reset: 50-cycle RX reset pulse, then WAIT_ALIGN one cycle later.
    sys_reset_in = 1'b0;
    count_reset_pulse("first reset pulse");
    check_eq("state at timer zero", 64'(dbg_state), 64'(S_RESET));
    step();
    check_eq("wait_align entry", 64'(dbg_state), 64'(S_WAIT));
    repeat (40) step();

    // Align while a frame is in flight: link_up 4 cycles later, and the
    // whole in-flight frame is dropped.
    stat_rx_aligned = 1'b1;
    for (int i = 0; i < 9; i++) begin
      beat(64'hA000 + 64'(i), (i == 8), 1'b1, 1'b0, "drop partial frame");
      if (i == 3) check_eq("link_up before 4 cycles", 64'(link_up), 64'd0);
      if (i == 4) begin
        check_eq("link_up after 4 cycles", 64'(link_up), 64'd1);
        check_eq("up tx_enable/rfi", 64'({ctl_tx_enable, ctl_tx_send_rfi}), 64'h2);
        check_eq("up retry_count", 64'(retry_count), 64'd0);
      end
      step();
    end
    for (int i = 0; i < 2; i++) begin
      beat(64'h0, 1'b0, 1'b0, 1'b0, "idle gap");
      step();
    end
    for (int i = 0; i < 4; i++) begin
      beat(64'hB000 + 64'(i), (i == 3), 1'b1, 1'b1, "whole frame passes");
      step();
    end
    beat(64'h0, 1'b0, 1'b0, 1'b0, "idle after frame");

    // Drop alignment while UP: beats pass for 4 more samples, then the gate
    // closes together with the move to RESET.
    stat_rx_aligned = 1'b0;
    for (int i = 0; i < 4; i++) begin
      beat(64'hC000 + 64'(i), 1'b1, 1'b1, 1'b1, "beats before loss seen");
      step();
    end
    beat(64'hC004, 1'b1, 1'b1, 1'b0, "gate closed on loss");
    check_eq("loss state", 64'(dbg_state), 64'(S_RESET));
    check_eq("loss link_up", 64'(link_up), 64'd0);
    count_reset_pulse("reset pulse after loss");
    step();
    check_eq("wait after loss", 64'(dbg_state), 64'(S_WAIT));
    w_cyc = cyc;
    for (int i = 0; i < 12; i++) begin
      beat(64'hD000 + 64'(i), 1'b1, 1'b1, 1'b0, "silent after reset");
      step();
    end
    rx_in_tvalid = 1'b0;
    check_eq("scoreboard drained", 64'(exp_q.size()), 64'd0);

    // Alignment timeouts: 2001 cycles in WAIT_ALIGN, then 2052 per retry.
    while (retry_count != 8'd1 && (cyc - w_cyc) < 3000) step();
    check_eq("timeout 1 latency", 64'(cyc - w_cyc), 64'd2001);
    check_eq("timeout 1 state", 64'(dbg_state), 64'(S_RESET));
    check_eq("timeout 1 sys_reset_out", 64'(sys_reset_out), 64'd1);
    t_cyc = cyc;
    while (retry_count != 8'd2 && (cyc - t_cyc) < 3000) step();
    check_eq("timeout 2 interval", 64'(cyc - t_cyc), 64'd2052);
    t_cyc = cyc;
    while (!link_failed && (cyc - t_cyc) < 3000) step();
    check_eq("timeout 3 interval", 64'(cyc - t_cyc), 64'd2052);
    check_eq("failed retry_count", 64'(retry_count), 64'd3);
    check_eq("failed state", 64'(dbg_state), 64'(S_FAIL));
    check_eq("failed sys_reset_out", 64'(sys_reset_out), 64'd0);
    check_eq("failed tx_enable/rfi", 64'({ctl_tx_enable, ctl_tx_send_rfi}), 64'h1);
    repeat (20) step();
    check_eq("failed held", 64'(link_failed), 64'd1);

    // reset_req leaves FAILED and clears the retry count.
    reset_req = 1'b1;
    step();
    reset_req = 1'b0;
    check_eq("req state", 64'(dbg_state), 64'(S_RESET));
    check_eq("req retry_count", 64'(retry_count), 64'd0);
    check_eq("req link_failed", 64'(link_failed), 64'd0);
    count_reset_pulse("reset pulse after req");

    // Two more up/down cycles: one ended by alignment loss, one by reset_req.
    wait_state("cycle 2 wait", S_WAIT, 100);
    stat_rx_aligned = 1'b1;
    wait_state("cycle 2 up", S_UP, 10);
    stat_rx_aligned = 1'b0;
    wait_state("cycle 2 down", S_RESET, 10);
    wait_state("cycle 3 wait", S_WAIT, 100);
    stat_rx_aligned = 1'b1;
    wait_state("cycle 3 up", S_UP, 10);
    reset_req = 1'b1;
    step();
    reset_req = 1'b0;
    stat_rx_aligned = 1'b0;
    check_eq("req from up state", 64'(dbg_state), 64'(S_RESET));
    check_eq("req from up link_up", 64'(link_up), 64'd0);
    repeat (5) step();
`ifdef CMAC_LINK_STATS_EN
    check_eq("link_up_count", 64'(link_up_count), 64'd3);
    check_eq("link_down_count", 64'(link_down_count), 64'd3);
`else
    check_eq("link_up_count", 64'(link_up_count), 64'd0);
    check_eq("link_down_count", 64'(link_down_count), 64'd0);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
